riscv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined RISC-V core.
- Replaces the bare PC register, PC+4 adder and next-PC mux of the single-cycle core.
- Owns the fetch PC and drives the combinational program-memory read port.
- Buffers fetched {pc, instruction} pairs in a FIFO of depth FIFO_DEPTH, and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush the buffer.

---
 rtl/riscv_fetch_unit.sv | 108 ++++++++++
 tb/tb_riscv_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads program memory
// combinationally, and buffers {pc, instr} pairs for decode in a small FIFO.
// Redirects flush the buffer and restart fetch from the aligned target.
module riscv_fetch_unit #(
    parameter int               XLEN         = 32,
    parameter int               FIFO_DEPTH   = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall_i,
    input  logic                              redirect_i,
    input  logic [XLEN-1:0]                   redirect_pc_i,
    output logic [XLEN-1:0]                   imem_addr_o,
    input  logic [XLEN-1:0]                   imem_rdata_i,
    output logic                              inst_valid_o,
    input  logic                              inst_ready_i,
    output logic [XLEN-1:0]                   inst_o,
    output logic [XLEN-1:0]                   inst_pc_o,
    output logic                              misaligned_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [XLEN-1:0]  pc_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             misaligned_reg;

    // Buffer storage: kept as reset registers so the head never reads X.
    logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0]  instr_mem [FIFO_DEPTH];

    logic             head_valid;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] count_next;

    assign head_valid = (count_reg != '0);

    // A redirect squashes whatever decode would have taken this cycle.
    assign pop  = head_valid & inst_ready_i & ~redirect_i;
    // Full buffer may still accept a fetch when the head leaves this cycle.
    assign push = ~redirect_i & ~stall_i & ((count_reg < DEPTH_CNT) | pop);

    // Occupancy update: net change of push minus pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Control state: fetch PC, pointers, occupancy and the sticky alignment flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_VECTOR;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            misaligned_reg <= 1'b0;
        end else if (redirect_i) begin
            pc_reg         <= {redirect_pc_i[XLEN-1:2], 2'b00};
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misaligned_reg <= 1'b1;
            end
        end else begin
            if (push) begin
                pc_reg     <= pc_reg + XLEN'(4);
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Buffer write: capture the fetched pair at the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_reg]    <= pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rdata_i;
        end
    end

    assign imem_addr_o  = pc_reg;
    assign inst_valid_o = head_valid;
    assign inst_o       = instr_mem[rd_ptr_reg];
    assign inst_pc_o    = pc_mem[rd_ptr_reg];
    assign misaligned_o = misaligned_reg;
    assign count_o      = count_reg;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: a queue-based model of the fetch buffer is
// advanced every clock and compared against the DUT, with directed scenarios
// pinning literal values and a randomized phase for broad coverage.
module tb_riscv_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        misaligned_o;
    logic [2:0]  count_o;

    logic [31:0] mem_key;

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic        m_mis;
    logic        m_known;
    logic        just_reset;

    riscv_fetch_unit #(
        .XLEN(32),
        .FIFO_DEPTH(DEPTH),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i),
        .inst_o(inst_o),
        .inst_pc_o(inst_pc_o),
        .misaligned_o(misaligned_o),
        .count_o(count_o)
    );

    // Program memory: word is the address, optionally scrambled by a key.
    assign imem_rdata_i = imem_addr_o ^ mem_key;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs with the model state for the current cycle.
    task automatic compare_model();
        logic [63:0] head;
        if (m_known) begin
            chk("imem_addr", imem_addr_o, m_pc);
            chk("count", 32'(count_o), 32'(m_q.size()));
            chk("valid", 32'(inst_valid_o), 32'(m_q.size() != 0));
            chk("misaligned", 32'(misaligned_o), 32'(m_mis));
            if (m_q.size() != 0) begin
                head = m_q[0];
                chk("inst_pc", inst_pc_o, head[63:32]);
                chk("inst", inst_o, head[31:0]);
            end
            if (just_reset) begin
                chk("rst_inst", inst_o, 32'h0);
                chk("rst_inst_pc", inst_pc_o, 32'h0);
            end
        end
    endtask

    // Advance the model by one clock using the applied inputs.
    task automatic update_model(input logic rst, input logic stl, input logic rdr,
                                input logic [31:0] rpc, input logic rdy);
        int          sz;
        logic        pop;
        logic [63:0] head;
        just_reset = rst;
        if (rst) begin
            m_pc    = 32'h0;
            m_q     = {};
            m_mis   = 1'b0;
            m_known = 1'b1;
        end else if (rdr) begin
            m_q  = {};
            m_pc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            sz  = m_q.size();
            pop = (sz != 0) && rdy;
            if (pop) begin
                head = m_q.pop_front();
                $display("pop pc=%h inst=%h", head[63:32], head[31:0]);
            end
            if (!stl && (sz < DEPTH || pop)) begin
                m_q.push_back({m_pc, m_pc ^ mem_key});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic rdr,
                        input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset         = rst;
        stall_i       = stl;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
        #1;
        compare_model();
        @(posedge clk);
        update_model(rst, stl, rdr, rpc, rdy);
        vectors++;
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        mem_key       = 32'h0;
        m_known       = 1'b0;
        just_reset    = 1'b0;
        m_pc          = 32'h0;
        m_mis         = 1'b0;
        reset         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b0;

        // Startup
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t1_valid0", 32'(inst_valid_o), 32'h0);
        chk("t1_addr0", imem_addr_o, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t1_valid1", 32'(inst_valid_o), 32'h1);
        chk("t1_pc0", inst_pc_o, 32'h0);
        chk("t1_inst0", inst_o, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t1_pc4", inst_pc_o, 32'h4);
        step(0, 0, 0, 0, 1);
        chk("t1_pc8", inst_pc_o, 32'h8);
        chk("t1_inst8", inst_o, 32'h8);

        // Back-pressure
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 0, 0);
            chk("t2_count", 32'(count_o), (k < 4) ? 32'(k) : 32'd4);
        end
        chk("t2_addr", imem_addr_o, 32'h10);
        chk("t2_head", inst_pc_o, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t2_full_pop_cnt", 32'(count_o), 32'd4);
        chk("t2_head4", inst_pc_o, 32'h4);
        step(0, 0, 0, 0, 1);
        chk("t2_head8", inst_pc_o, 32'h8);
        chk("t2_cnt_hold", 32'(count_o), 32'd4);

        // Redirect mid-stream
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t3_head8", inst_pc_o, 32'h8);
        step(0, 0, 1, 32'h40, 1);
        chk("t3_cnt0", 32'(count_o), 32'h0);
        chk("t3_valid0", 32'(inst_valid_o), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t3_head40", inst_pc_o, 32'h40);
        step(0, 0, 0, 0, 1);
        chk("t3_head44", inst_pc_o, 32'h44);

        // Misaligned redirect
        step(0, 0, 1, 32'h22, 1);
        chk("t4_mis", 32'(misaligned_o), 32'h1);
        chk("t4_addr", imem_addr_o, 32'h20);
        step(0, 0, 0, 0, 1);
        chk("t4_head20", inst_pc_o, 32'h20);
        step(0, 0, 1, 32'h100, 1);
        step(0, 0, 0, 0, 1);
        chk("t4_sticky", 32'(misaligned_o), 32'h1);
        step(1, 0, 0, 0, 0);
        chk("t4_clear", 32'(misaligned_o), 32'h0);

        // Stall versus redirect
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t5_cnt3", 32'(count_o), 32'd3);
        for (int k = 2; k >= 0; k--) begin
            step(0, 1, 0, 0, 1);
            chk("t5_drain", 32'(count_o), 32'(k));
        end
        chk("t5_valid0", 32'(inst_valid_o), 32'h0);
        chk("t5_frozen", imem_addr_o, 32'hC);
        step(0, 1, 1, 32'h80, 1);
        chk("t5_addr80", imem_addr_o, 32'h80);
        step(0, 1, 0, 0, 1);
        chk("t5_nopush", 32'(count_o), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("t5_head80", inst_pc_o, 32'h80);

        // Reset overrides a simultaneous redirect
        step(0, 0, 1, 32'h33, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
        chk("t6_full", 32'(count_o), 32'd4);
        step(1, 0, 1, 32'h80, 1);
        chk("t6_addr", imem_addr_o, 32'h0);
        chk("t6_cnt", 32'(count_o), 32'h0);
        chk("t6_mis", 32'(misaligned_o), 32'h0);

        // Randomized phase with a scrambled memory image
        mem_key = 32'h5A5A_1234;
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        rst;
            logic        rdr;
            logic        stl;
            logic        rdy;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 199) == 0);
            rdr = ($urandom_range(0, 19) == 0);
            stl = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                rpc = $urandom & 32'h0000_0FFF;
            step(rst, stl, rdr, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
